// File: rtl/matrix_alu_seq.sv
// Sequential N x N matrix ALU: transpose, add, sub, multiply and scale over operand
// matrices E, F and scalar c, writing result matrix G one element step per cycle.
module matrix_alu_seq #(
  parameter int unsigned N  = 3,
  parameter int unsigned W  = 32,
  parameter int unsigned AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          start,
  input  logic [2:0]    op,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          err
);
  localparam int unsigned NE = N * N;
  localparam int unsigned FW = 2 * W + 2;
  localparam logic [AW:0] NeA = (AW + 1)'(NE);
  localparam logic [2:0] Last = 3'(N - 1);
  localparam logic [2:0] OpT     = 3'd0;
  localparam logic [2:0] OpAdd   = 3'd1;
  localparam logic [2:0] OpSub   = 3'd2;
  localparam logic [2:0] OpMul   = 3'd3;
  localparam logic [2:0] OpScale = 3'd4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [W-1:0] e_q [NE];
  logic [W-1:0] e_d [NE];
  logic [W-1:0] f_q [NE];
  logic [W-1:0] f_d [NE];
  logic [W-1:0] g_q [NE];
  logic [W-1:0] g_d [NE];
  logic [W-1:0] c_q, c_d;
  logic signed [FW-1:0] acc_q, acc_d;
  logic [2:0] op_q, op_d;
  logic [2:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic ovf_q, ovf_d, err_q, err_d, done_q, done_d;
  // A write that lands on the same edge as an accepted start is parked here and
  // committed in DONE, so the running op still sees the pre-write operands.
  logic          pend_q, pend_d;
  logic [1:0]    pend_sel_q, pend_sel_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [W-1:0]  pend_data_q, pend_data_d;

  logic          accept, el_step, last_el, fits, wvalid;
  logic [1:0]    wsel;
  logic [AW-1:0] waddr, idx_ij, idx_ji, idx_ik, idx_kj;
  logic [W-1:0]  wdata;
  logic signed [FW-1:0] e_ij, f_ij, e_ji, c_x, prod, acc_base, full_val;
  logic [FW-W:0] upper;

  assign accept  = (state_q == StIdle) && start && !done_q;
  assign el_step = (state_q == StRun) && ((op_q != OpMul) || (k_q == Last));
  assign last_el = (i_q == Last) && (j_q == Last);

  // Full-precision element value; overflow when it does not fit in W signed bits.
  always_comb begin
    idx_ij   = AW'(i_q * N + j_q);
    idx_ji   = AW'(j_q * N + i_q);
    idx_ik   = AW'(i_q * N + k_q);
    idx_kj   = AW'(k_q * N + j_q);
    e_ij     = FW'($signed(e_q[idx_ij]));
    f_ij     = FW'($signed(f_q[idx_ij]));
    e_ji     = FW'($signed(e_q[idx_ji]));
    c_x      = FW'($signed(c_q));
    prod     = FW'($signed(e_q[idx_ik])) * FW'($signed(f_q[idx_kj]));
    acc_base = (k_q == '0) ? '0 : acc_q;
    case (op_q)
      OpT:     full_val = e_ji;
      OpAdd:   full_val = e_ij + f_ij;
      OpSub:   full_val = e_ij - f_ij;
      OpMul:   full_val = acc_base + prod;
      default: full_val = c_x * e_ij;
    endcase
    upper = full_val[FW-1:W-1];
    fits  = (upper == '0) || (upper == '1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (op > OpScale) ? StDone : StRun;
      StRun:   if (el_step && last_el) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = done_q;
    ovf     = ovf_q;
    err     = err_q;
    rd_data = '0;
    if ({1'b0, rd_addr} < NeA) rd_data = g_q[rd_addr];
  end

  always_comb begin
    e_d = e_q;
    f_d = f_q;
    g_d = g_q;
    c_d = c_q;
    acc_d = acc_q;
    op_d = op_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    ovf_d = ovf_q;
    err_d = err_q;
    done_d = (state_q == StDone);
    pend_d = pend_q;
    pend_sel_d = pend_sel_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wvalid = 1'b0;
    wsel = wr_sel;
    waddr = wr_addr;
    wdata = wr_data;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = op;
          ovf_d = 1'b0;
          err_d = (op > OpScale);
          i_d   = '0;
          j_d   = '0;
          k_d   = '0;
          if (wr_en) begin
            pend_d      = 1'b1;
            pend_sel_d  = wr_sel;
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
          end
        end else if (wr_en) begin
          wvalid = 1'b1;
        end
      end
      StRun: begin
        if (op_q == OpMul) begin
          acc_d = full_val;
          k_d   = (k_q == Last) ? 3'd0 : k_q + 3'd1;
        end
        if (el_step) begin
          g_d[idx_ij] = full_val[W-1:0];
          if (!fits) ovf_d = 1'b1;
          if (j_q == Last) begin
            j_d = '0;
            i_d = i_q + 3'd1;
          end else begin
            j_d = j_q + 3'd1;
          end
        end
      end
      StDone: begin
        if (pend_q) begin
          wvalid = 1'b1;
          wsel   = pend_sel_q;
          waddr  = pend_addr_q;
          wdata  = pend_data_q;
          pend_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (wvalid) begin
      case (wsel)
        2'd0:    if ({1'b0, waddr} < NeA) e_d[waddr] = wdata;
        2'd1:    if ({1'b0, waddr} < NeA) f_d[waddr] = wdata;
        2'd2:    c_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q         <= '{default: '0};
      f_q         <= '{default: '0};
      g_q         <= '{default: '0};
      c_q         <= '0;
      acc_q       <= '0;
      op_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      e_q         <= e_d;
      f_q         <= f_d;
      g_q         <= g_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Scoreboard bench for matrix_alu_seq (N=3, W=32): a reference model predicts G,
// ovf and err at each start; results are popped and compared when done fires.
module tb_matrix_alu_seq;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic          busy, done, ovf, err;

  typedef struct packed {
    logic ovf;
    logic err;
    logic [8:0][31:0] g;
  } res_t;

  res_t exp_q[$];
  logic [31:0] me[9];
  logic [31:0] mf[9];
  logic [31:0] mg[9];
  logic [31:0] mc;
  int checks = 0;
  int failures = 0;
  time t_start;

  matrix_alu_seq #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .op(op),
    .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [2:0] opc);
    res_t r;
    longint v;
    r = '0;
    for (int n = 0; n < 9; n++) r.g[n] = mg[n];
    if (opc > 3'd4) begin
      r.err = 1'b1;
      return r;
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        case (opc)
          3'd0: v = longint'($signed(me[j*3+i]));
          3'd1: v = longint'($signed(me[i*3+j])) + longint'($signed(mf[i*3+j]));
          3'd2: v = longint'($signed(me[i*3+j])) - longint'($signed(mf[i*3+j]));
          3'd3: begin
            v = 0;
            for (int k = 0; k < 3; k++)
              v += longint'($signed(me[i*3+k])) * longint'($signed(mf[k*3+j]));
          end
          default: v = longint'($signed(mc)) * longint'($signed(me[i*3+j]));
        endcase
        if (v > 64'sd2147483647 || v < -64'sd2147483648) r.ovf = 1'b1;
        r.g[i*3+j] = v[31:0];
      end
    end
    return r;
  endfunction

  task automatic push_expect(input logic [2:0] opc);
    res_t r;
    r = model(opc);
    exp_q.push_back(r);
    for (int n = 0; n < 9; n++) mg[n] = r.g[n];
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic wr(input logic [1:0] sel, input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel == 2'd0 && addr < 9) me[addr] = data;
    if (sel == 2'd1 && addr < 9) mf[addr] = data;
    if (sel == 2'd2) mc = data;
  endtask

  task automatic pulse_start(input logic [2:0] opc);
    op = opc; start = 1'b1;
    @(posedge clk);
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
    if (opc <= 3'd4) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_after_start op=%0d: got %b want 1", opc, busy);
      end
    end
  endtask

  task automatic start_op(input logic [2:0] opc);
    push_expect(opc);
    pulse_start(opc);
  endtask

  // Waits for done, checks latency, flags and all of G; optionally pokes start
  // during the done cycle, which must be ignored.
  task automatic finish_op(input int exp_lat, input string name, input bit poke);
    res_t e;
    int guard;
    int lat;
    guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: done got %b want 1 within 2000 cycles", name, done);
    end
    lat = int'(($time - t_start - 5) / 10);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_at_done: got %b want 0", name, busy);
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard: got empty queue want an entry", name);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    checks++;
    if (ovf !== e.ovf) begin
      failures++;
      $display("FAIL %s_ovf: got %b want %b", name, ovf, e.ovf);
    end
    checks++;
    if (err !== e.err) begin
      failures++;
      $display("FAIL %s_err: got %b want %b", name, err, e.err);
    end
    if (poke) begin
      op = 3'd1;
      start = 1'b1;
    end
    for (int a = 0; a < 9; a++) begin
      rd_addr = AW'(a);
      #1;
      checks++;
      if (rd_data !== e.g[a]) begin
        failures++;
        $display("FAIL %s_g[%0d]: got %h want %h", name, a, rd_data, e.g[a]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    if (poke) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_start_in_done: busy got %b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ovf, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, ovf, err});
    end
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 9; a++) begin
      rd_addr = AW'(a);
      #1;
      checks++;
      if (rd_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_g[%0d]: got %h want 0", a, rd_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_transpose;
    for (int n = 0; n < 9; n++) wr(2'd0, n, 32'(n + 1));
    start_op(3'd0);
    finish_op(10, "transpose", 1'b0);
  endtask

  task automatic test_add_sub;
    for (int n = 0; n < 9; n++) wr(2'd1, n, 32'(9 - n));
    start_op(3'd1);
    finish_op(10, "add", 1'b0);
    start_op(3'd2);
    finish_op(10, "sub", 1'b0);
  endtask

  task automatic test_multiply;
    for (int n = 0; n < 9; n++) wr(2'd1, n, (n % 4 == 0) ? 32'd1 : 32'd0);
    start_op(3'd3);
    finish_op(28, "mul_identity", 1'b0);
    for (int n = 0; n < 9; n++) wr(2'd1, n, 32'(n + 1));
    start_op(3'd3);
    finish_op(28, "mul_square", 1'b0);
  endtask

  task automatic test_overflow_scale;
    wr(2'd0, 0, 32'h7FFF_FFFF);
    wr(2'd1, 0, 32'd1);
    start_op(3'd1);
    finish_op(10, "add_ovf", 1'b0);
    wr(2'd0, 0, 32'h0001_0000);
    for (int n = 0; n < 9; n++) wr(2'd1, n, (n % 4 == 0) ? 32'd1 : 32'd0);
    wr(2'd1, 0, 32'h0001_0000);
    start_op(3'd3);
    finish_op(28, "mul_ovf", 1'b0);
    wr(2'd0, 0, 32'd1);
    wr(2'd2, 0, 32'hFFFF_FFFE);
    start_op(3'd4);
    finish_op(10, "scale", 1'b0);
  endtask

  task automatic test_handshake;
    int extra;
    start_op(3'd0);
    repeat (3) @(negedge clk);
    op = 3'd1; start = 1'b1;
    wr_en = 1'b1; wr_sel = 2'd0; wr_addr = AW'(4); wr_data = 32'd99;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    finish_op(10, "busy_start", 1'b0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL extra_done: got %0d pulses want 0", extra);
    end
    start_op(3'd0);
    finish_op(10, "write_in_busy", 1'b0);
    start_op(3'd6);
    finish_op(1, "illegal", 1'b0);
  endtask

  task automatic test_back_to_back;
    wr(2'd0, 9, 32'd555);
    wr(2'd3, 0, 32'd777);
    start_op(3'd1);
    finish_op(10, "b2b_add", 1'b1);
    start_op(3'd2);
    finish_op(10, "b2b_sub", 1'b0);
    push_expect(3'd0);
    wr_en = 1'b1; wr_sel = 2'd0; wr_addr = AW'(1); wr_data = 32'd50;
    pulse_start(3'd0);
    wr_en = 1'b0;
    me[1] = 32'd50;
    finish_op(10, "wr_with_start", 1'b0);
    start_op(3'd0);
    finish_op(10, "wr_committed", 1'b0);
    rd_addr = AW'(12);
    #1;
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL read_out_of_range: got %h want 0", rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    pulse_start(3'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_flags: got %b want 0000", {busy, done, ovf, err});
    end
    for (int n = 0; n < 9; n++) begin
      me[n] = '0; mf[n] = '0; mg[n] = '0;
    end
    mc = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 9; a++) begin
      rd_addr = AW'(a);
      #1;
      checks++;
      if (rd_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_mid_g[%0d]: got %h want 0", a, rd_data);
      end
    end
    @(negedge clk);
    for (int n = 0; n < 9; n++) wr(2'd0, n, 32'(10 * n + 3));
    start_op(3'd0);
    finish_op(10, "after_reset", 1'b0);
  endtask

  initial begin
    for (int n = 0; n < 9; n++) begin
      me[n] = '0; mf[n] = '0; mg[n] = '0;
    end
    mc = '0;
    test_reset();
    test_transpose();
    test_add_sub();
    test_multiply();
    test_overflow_scale();
    test_handshake();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
